rx_deser_param: RTL and testbench
=================================

RX_DESER_PARAM -- requirements
Module: rx_deser_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bits per word (legal 5..16).
REQ-002 SHALL have parameter PARITY_ODD, default 0, parity sense: 0 even, 1 odd (used only with RX_DESER_PARITY_EN).
REQ-003 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port deser_en  input  1  frame active; low aborts any partial word.
REQ-006 SHALL have port sample_valid  input  1  one-cycle strobe, sampled_bit valid this cycle.
REQ-007 SHALL have port sampled_bit  input  1  recovered serial bit.
REQ-008 SHALL have port msb_first  input  1  bit order: 0 LSB first (UART), 1 MSB first; sampled at the first bit of each word.
REQ-009 SHALL have port out_ready  input  1  consumer accepts p_data when p_valid high.
REQ-010 SHALL have port clr_overrun  input  1  clears sticky overrun.
REQ-011 SHALL have port p_data  output  DATA_W  assembled word.
REQ-012 SHALL have port p_valid  output  1  p_data holds an unconsumed word.
REQ-013 SHALL have port overrun  output  1  sticky, word lost.
REQ-014 SHALL have port parity_err  output  1  parity mismatch for word in p_data (present only with RX_DESER_PARITY_EN).

Function
REQ-015 SHALL implement states IDLE (count 0), SHIFT (collecting data bits), PAR (awaiting parity bit, macro only).
REQ-016 SHALL, on sample_valid with deser_en high, accept one bit: IDLE->SHIFT latches msb_first into an order register; bit stored at position count (LSB first) or DATA_W-1-count (MSB first); count increments.
REQ-017 SHALL, on the DATA_W-th data bit, complete the word (without macro) or go to PAR (with macro); word completes on the parity bit.
REQ-018 SHALL, on completion, return to IDLE with count 0 in the same edge.
REQ-019 SHALL present a completed word on p_data with p_valid high one clock after the edge that accepted its last bit.
REQ-020 SHALL hold p_data, p_valid, parity_err stable while p_valid high and out_ready low.
REQ-021 SHALL drop p_valid on the edge where p_valid and out_ready are both high, unless a new word loads on that edge.
REQ-022 SHALL, when a word completes while p_valid high and out_ready low, discard the new word, keep the old, set overrun.
REQ-023 SHALL, when a word completes on the same edge the old is consumed, load the new word with p_valid staying high, no overrun.
REQ-024 SHALL clear overrun on clr_overrun; an overrun event on the same edge wins (overrun stays 1).
REQ-025 SHALL, when deser_en low, force IDLE, clear count and the partial shift register; p_data/p_valid unaffected.
REQ-026 SHALL ignore sample_valid while deser_en low, and ignore sampled_bit without sample_valid.
REQ-027 SHALL keep count width ceil(log2(DATA_W+2)) bits, never exceeding DATA_W.

Reset
REQ-028 SHALL, with rst low, asynchronously force IDLE, count 0, shift register 0, p_data 0, p_valid 0, overrun 0, parity_err 0.
REQ-029 SHALL, on rst low mid-word, discard the partial word; first bit after release starts a new word.

Configuration
REQ-030 SHALL compile parity support only when macro RX_DESER_PARITY_EN is defined.
REQ-031 SHALL, with RX_DESER_PARITY_EN: expect one parity bit after the data bits; parity_err = (XOR of data bits XOR parity bit) != PARITY_ODD, loaded with p_data.
REQ-032 SHALL, without RX_DESER_PARITY_EN: omit PAR state and parity_err port; DATA_W bits per word.

Verification
REQ-033 SHALL verify LSB-first: DATA_W=8, msb_first=0, bits 1,0,1,0,0,1,0,1 -> p_data 0xA5, p_valid one clock after last bit.
REQ-034 SHALL verify MSB-first: same bits, msb_first=1 -> p_data 0xA5 reversed = 0xA5 pattern check with 0x0F bits 0,0,0,0,1,1,1,1 -> 0x0F.
REQ-035 SHALL verify backpressure: out_ready low, two words 0x11 then 0x22 -> p_data 0x11, overrun 1; clr_overrun -> overrun 0.
REQ-036 SHALL verify abort: 5 bits, deser_en low one cycle, then 8 bits of 0x3C -> p_data 0x3C.
REQ-037 SHALL verify parity (macro, even): 0x07 with parity bit 1 -> parity_err 0; parity bit 0 -> parity_err 1.
REQ-038 SHALL verify reset mid-word: rst low after 4 bits -> all outputs 0; next 8 bits give a correct word.

Source files
------------

// File: rtl/rx_deser_param.sv
// rx_deser_param -- serial-to-parallel word assembler for a recovered bit stream.
//
// Bits arrive one at a time on sample_valid strobes. The design collects DATA_W of
// them, either LSB first (UART style) or MSB first, and hands the finished word to
// a single-entry output register with a valid/ready handshake. The bit order is
// latched from msb_first on the first bit of each word.
//
// Optional feature macro: RX_DESER_PARITY_EN
//   When defined, one parity bit follows the data bits, and the parity_err port is
//   present. PARITY_ODD selects the sense: 0 = even, 1 = odd.
//   When undefined, words are exactly DATA_W bits and there is no parity_err port.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-low reset
//   deser_en     frame active; low aborts any partial word
//   sample_valid one-cycle strobe qualifying sampled_bit
//   sampled_bit  recovered serial bit
//   msb_first    bit order for the next word (0 LSB first, 1 MSB first)
//   out_ready    consumer takes p_data while p_valid is high
//   clr_overrun  clears the sticky overrun flag
//   p_data       assembled word
//   p_valid      p_data holds an unconsumed word
//   overrun      sticky: a finished word was dropped because p_data was still full
//   parity_err   parity mismatch for the word in p_data (macro builds only)

module rx_deser_param #(
    parameter int DATA_W     = 8,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              deser_en,
    input  logic              sample_valid,
    input  logic              sampled_bit,
    input  logic              msb_first,
    input  logic              out_ready,
    input  logic              clr_overrun,
    output logic [DATA_W-1:0] p_data,
    output logic              p_valid,
    output logic              overrun
`ifdef RX_DESER_PARITY_EN
    ,
    output logic              parity_err
`endif
);

    localparam int CW = $clog2(DATA_W + 2);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
`ifdef RX_DESER_PARITY_EN
    localparam logic [1:0] ST_PAR   = 2'd2;
`endif

    if (DATA_W < 5 || DATA_W > 16 || PARITY_ODD > 1'b1) begin : g_bad_param
        $error("rx_deser_param: DATA_W must be 5..16");
    end

    // Assembly side
    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              order_q, order_d;

    // Finished word waiting one cycle before it reaches the output register
    logic              done_q, done_d;
    logic [DATA_W-1:0] word_q, word_d;

    // Output register
    logic [DATA_W-1:0] p_data_q, p_data_d;
    logic              p_valid_q, p_valid_d;
    logic              overrun_q, overrun_d;

`ifdef RX_DESER_PARITY_EN
    logic              wperr_q, wperr_d;
    logic              perr_q, perr_d;
`endif

    logic              cur_order;
    logic [CW-1:0]     bit_idx;
    logic [DATA_W-1:0] asm_word;
    logic              ovr_event;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        shift_d  = shift_q;
        order_d  = order_q;
        done_d   = 1'b0;
        word_d   = word_q;
`ifdef RX_DESER_PARITY_EN
        wperr_d  = wperr_q;
`endif
        // The first bit of a word uses the live msb_first; later bits use the latched copy.
        cur_order = (state_q == ST_IDLE) ? msb_first : order_q;
        bit_idx   = cur_order ? (CW'(DATA_W - 1) - count_q) : count_q;

        // shift_q is zero whenever a word starts, so writing one position is enough.
        asm_word = shift_q;
        for (int i = 0; i < DATA_W; i++) begin
            if (i == int'(bit_idx)) asm_word[i] = sampled_bit;
        end

        if (!deser_en) begin
            state_d = ST_IDLE;
            count_d = '0;
            shift_d = '0;
        end else if (sample_valid) begin
            unique case (state_q)
                ST_IDLE, ST_SHIFT: begin
                    if (state_q == ST_IDLE) order_d = msb_first;
                    if (count_q == CW'(DATA_W - 1)) begin
`ifdef RX_DESER_PARITY_EN
                        state_d = ST_PAR;
                        count_d = CW'(DATA_W);
                        shift_d = asm_word;
`else
                        state_d = ST_IDLE;
                        count_d = '0;
                        shift_d = '0;
                        done_d  = 1'b1;
                        word_d  = asm_word;
`endif
                    end else begin
                        state_d = ST_SHIFT;
                        count_d = count_q + CW'(1);
                        shift_d = asm_word;
                    end
                end
`ifdef RX_DESER_PARITY_EN
                ST_PAR: begin
                    state_d = ST_IDLE;
                    count_d = '0;
                    shift_d = '0;
                    done_d  = 1'b1;
                    word_d  = shift_q;
                    wperr_d = ((^shift_q) ^ sampled_bit) != PARITY_ODD;
                end
`endif
                default: begin
                    state_d = ST_IDLE;
                    count_d = '0;
                    shift_d = '0;
                end
            endcase
        end
    end

    // Output register: a finished word either loads (slot empty or being consumed
    // on this edge) or is dropped and flagged as overrun.
    always_comb begin
        p_data_d  = p_data_q;
        p_valid_d = p_valid_q;
        ovr_event = 1'b0;
`ifdef RX_DESER_PARITY_EN
        perr_d    = perr_q;
`endif
        if (done_q) begin
            if (p_valid_q && !out_ready) begin
                ovr_event = 1'b1;
            end else begin
                p_data_d  = word_q;
                p_valid_d = 1'b1;
`ifdef RX_DESER_PARITY_EN
                perr_d    = wperr_q;
`endif
            end
        end else if (p_valid_q && out_ready) begin
            p_valid_d = 1'b0;
        end

        // A new overrun on the same edge beats the clear.
        overrun_d = overrun_q;
        if (clr_overrun) overrun_d = 1'b0;
        if (ovr_event)   overrun_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            shift_q   <= '0;
            order_q   <= 1'b0;
            done_q    <= 1'b0;
            word_q    <= '0;
            p_data_q  <= '0;
            p_valid_q <= 1'b0;
            overrun_q <= 1'b0;
`ifdef RX_DESER_PARITY_EN
            wperr_q   <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            shift_q   <= shift_d;
            order_q   <= order_d;
            done_q    <= done_d;
            word_q    <= word_d;
            p_data_q  <= p_data_d;
            p_valid_q <= p_valid_d;
            overrun_q <= overrun_d;
`ifdef RX_DESER_PARITY_EN
            wperr_q   <= wperr_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign p_data  = p_data_q;
    assign p_valid = p_valid_q;
    assign overrun = overrun_q;
`ifdef RX_DESER_PARITY_EN
    assign parity_err = perr_q;
`endif

endmodule

// File: tb/tb_rx_deser_param.sv
// Directed bench for rx_deser_param (DATA_W = 8, even parity when the parity
// macro is defined). A bit-queue model predicts the outputs and is compared on
// every falling edge; hand-computed literals pin the key scenarios.

module tb_rx_deser_param;

    localparam int DW = 8;
    localparam bit PODD = 1'b0;
`ifdef RX_DESER_PARITY_EN
    localparam int NB = DW + 1;
`else
    localparam int NB = DW;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          deser_en = 1'b0;
    logic          sample_valid = 1'b0;
    logic          sampled_bit = 1'b0;
    logic          msb_first = 1'b0;
    logic          out_ready = 1'b0;
    logic          clr_overrun = 1'b0;
    logic [DW-1:0] p_data;
    logic          p_valid;
    logic          overrun;
    logic          parity_err;

    int checks = 0;
    int errors = 0;

    rx_deser_param #(.DATA_W(DW), .PARITY_ODD(PODD)) dut (
        .clk          (clk),
        .rst          (rst),
        .deser_en     (deser_en),
        .sample_valid (sample_valid),
        .sampled_bit  (sampled_bit),
        .msb_first    (msb_first),
        .out_ready    (out_ready),
        .clr_overrun  (clr_overrun),
        .p_data       (p_data),
        .p_valid      (p_valid),
        .overrun      (overrun)
`ifdef RX_DESER_PARITY_EN
        ,
        .parity_err   (parity_err)
`endif
    );

`ifndef RX_DESER_PARITY_EN
    assign parity_err = 1'b0;
`endif

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Bits of the current word are kept in a queue; a finished word becomes
    // visible one edge after its last bit was taken.
    bit            mq[$];
    bit            m_ord = 1'b0;
    bit            pend = 1'b0;
    logic [DW-1:0] pend_w = '0;
    bit            pend_pe = 1'b0;
    bit            par_acc = 1'b0;
    logic [DW-1:0] m_data = '0;
    bit            m_valid = 1'b0;
    bit            m_ovr = 1'b0;
    bit            m_perr = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            pend = 1'b0; m_data = '0; m_valid = 1'b0; m_ovr = 1'b0; m_perr = 1'b0;
        end else begin
            if (clr_overrun) m_ovr = 1'b0;
            if (pend) begin
                if (m_valid && !out_ready) m_ovr = 1'b1;
                else begin
                    m_data = pend_w; m_perr = pend_pe; m_valid = 1'b1;
                end
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
            pend = 1'b0;
            if (!deser_en) mq.delete();
            else if (sample_valid) begin
                if (mq.size() == 0) m_ord = msb_first;
                mq.push_back(sampled_bit);
                if (mq.size() == NB) begin
                    pend_w = '0;
                    par_acc = 1'b0;
                    for (int i = 0; i < NB; i++) par_acc ^= mq[i];
                    for (int i = 0; i < DW; i++) begin
                        if (m_ord) pend_w[DW-1-i] = mq[i];
                        else       pend_w[i]      = mq[i];
                    end
                    pend_pe = (par_acc != PODD);
                    pend = 1'b1;
                    mq.delete();
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        checks++;
        if (p_data !== m_data || p_valid !== m_valid || overrun !== m_ovr
`ifdef RX_DESER_PARITY_EN
            || parity_err !== m_perr
`endif
        ) begin
            errors++;
            $display("FAIL model_cmp t=%0t got data=%h vld=%b ovr=%b perr=%b want data=%h vld=%b ovr=%b perr=%b",
                     $time, p_data, p_valid, overrun, parity_err, m_data, m_valid, m_ovr, m_perr);
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Optional idle cycle with junk on sampled_bit, then one strobed bit.
    task automatic send_bit(input bit b);
        if ($urandom_range(0, 1) == 1) begin
            sample_valid = 1'b0;
            sampled_bit  = 1'($urandom);
            tick();
        end
        sample_valid = 1'b1;
        sampled_bit  = b;
        tick();
        sample_valid = 1'b0;
        sampled_bit  = 1'($urandom);
    endtask

    // Sends w in the chosen order; in parity builds a parity bit follows,
    // correct unless flip is set.
    task automatic send_word(input logic [DW-1:0] w, input bit msb, input bit flip);
        msb_first = msb;
        for (int i = 0; i < DW; i++) send_bit(msb ? w[DW-1-i] : w[i]);
`ifdef RX_DESER_PARITY_EN
        send_bit((^w) ^ PODD ^ flip);
`else
        if (flip) $display("note: flip ignored without parity");
`endif
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic pulse_clr();
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [DW-1:0] a5_lsb;
        rst = 1'b0;
        tick(); tick();
        chk("reset_pvalid", 32'(p_valid), 32'd0);
        chk("reset_pdata", 32'(p_data), 32'd0);
        chk("reset_overrun", 32'(overrun), 32'd0);
        rst = 1'b1;
        deser_en = 1'b1;
        tick();

        // LSB first: 1,0,1,0,0,1,0,1 -> 0xA5, valid one edge after the last bit
        a5_lsb = 8'hA5;
        send_word(a5_lsb, 1'b0, 1'b0);
        chk("lsb_latency_low", 32'(p_valid), 32'd0);
        tick();
        chk("lsb_pvalid", 32'(p_valid), 32'd1);
        chk("lsb_pdata", 32'(p_data), 32'hA5);
        consume();
        chk("lsb_consumed", 32'(p_valid), 32'd0);

        // MSB first: 0,0,0,0,1,1,1,1 -> 0x0F
        send_word(8'h0F, 1'b1, 1'b0);
        tick();
        chk("msb_pdata", 32'(p_data), 32'h0F);
        chk("msb_hold_while_not_ready", 32'(p_valid), 32'd1);
        consume();

        // Backpressure: second word dropped, overrun set, then cleared
        send_word(8'h11, 1'b0, 1'b0);
        tick();
        send_word(8'h22, 1'b0, 1'b0);
        tick();
        chk("bp_pdata_kept", 32'(p_data), 32'h11);
        chk("bp_overrun", 32'(overrun), 32'd1);
        pulse_clr();
        chk("bp_overrun_cleared", 32'(overrun), 32'd0);
        chk("bp_still_valid", 32'(p_valid), 32'd1);

        // New word loads on the same edge the old one is consumed
        send_word(8'h81, 1'b1, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("swap_pvalid", 32'(p_valid), 32'd1);
        chk("swap_pdata", 32'(p_data), 32'h81);
        chk("swap_no_overrun", 32'(overrun), 32'd0);
        consume();

        // Overrun event and clr_overrun on the same edge: overrun stays set
        send_word(8'h42, 1'b0, 1'b0);
        tick();
        send_word(8'h99, 1'b0, 1'b0);
        clr_overrun = 1'b1;
        tick();
        clr_overrun = 1'b0;
        chk("clr_race_overrun", 32'(overrun), 32'd1);
        chk("clr_race_pdata", 32'(p_data), 32'h42);
        pulse_clr();
        consume();

        // Abort: 5 bits, deser_en low one cycle, then 0x3C
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        deser_en = 1'b0;
        tick();
        deser_en = 1'b1;
        send_word(8'h3C, 1'b0, 1'b0);
        tick();
        chk("abort_pdata", 32'(p_data), 32'h3C);
        chk("abort_pvalid", 32'(p_valid), 32'd1);

        // Reset mid-word with a word still held: everything clears asynchronously
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_pdata", 32'(p_data), 32'd0);
        chk("rst_mid_pvalid", 32'(p_valid), 32'd0);
        chk("rst_mid_overrun", 32'(overrun), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        send_word(8'h5A, 1'b0, 1'b0);
        tick();
        chk("rst_after_pdata", 32'(p_data), 32'h5A);
        consume();

`ifdef RX_DESER_PARITY_EN
        // Even parity: 0x07 with parity 1 is good, with parity 0 is an error
        send_word(8'h07, 1'b0, 1'b0);
        tick();
        chk("par_good_pdata", 32'(p_data), 32'h07);
        chk("par_good_err", 32'(parity_err), 32'd0);
        consume();
        send_word(8'h07, 1'b0, 1'b1);
        tick();
        chk("par_bad_err", 32'(parity_err), 32'd1);
        consume();
`endif

        tick(); tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
